// File: rtl/flash_cmd_sequencer.sv
// Sequences WREN / user opcode / RDSR-poll commands on the shared SPI memory master
// and arbitrates that master between this engine and the memory-SPI bridge.
module flash_cmd_sequencer #(
  parameter int unsigned POLL_MAX = 65535,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_start,
  input  logic [7:0]  i_cmd_opcode,
  input  logic        i_cmd_has_addr,
  input  logic [23:0] i_cmd_addr,
  output logic        o_cmd_busy,
  output logic        o_cmd_done,
  output logic        o_cmd_error,
  output logic [7:0]  o_status_byte,
  input  logic        i_bus_req,
  output logic        o_bus_grant,
  output logic [7:0]  o_m_opcode,
  output logic [23:0] o_m_addr,
  output logic        o_m_addr_flag,
  output logic        o_m_oa_trigger,
  input  logic        i_m_oa_completed,
  output logic        o_m_data_trigger,
  input  logic        i_m_data_completed,
  input  logic [7:0]  i_m_read_data,
  output logic        o_m_finalize,
  input  logic        i_m_busy
);

  localparam int unsigned CNT_W = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
  localparam int unsigned GAP_W = (CS_GAP < 2) ? 1 : $clog2(CS_GAP);
  localparam logic [CNT_W:0]   CNT_LIMIT = (CNT_W + 1)'(POLL_MAX);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((CS_GAP == 0) ? 0 : CS_GAP - 1);
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_BUS, S_WREN_OA, S_WREN_FIN, S_OP_OA, S_OP_FIN,
    S_RDSR_OA, S_RDSR_DATA, S_RDSR_FIN, S_DONE, S_ERR
  } state_t;

  // Finalize sub-phases: pulse, let master see it, wait not-busy, CS-high gap.
  typedef enum logic [1:0] {F_PULSE, F_HOLD, F_WAIT, F_GAP} fin_ph_t;

  state_t         r_state, w_state_nxt;
  fin_ph_t        r_fin_ph, w_fin_ph_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [CNT_W-1:0] r_poll_cnt, w_poll_cnt_nxt;
  logic [CNT_W:0]   w_cnt_inc;
  logic           r_err_pend, w_err_pend_nxt;
  logic           r_rearm, w_rearm_nxt;
  logic [7:0]     r_op, w_op_nxt;
  logic [23:0]    r_addr, w_addr_nxt;
  logic           r_has_addr, w_has_addr_nxt;
  logic           r_cmd_busy, w_cmd_busy_nxt;
  logic           r_cmd_done, w_cmd_done_nxt;
  logic           r_cmd_error, w_cmd_error_nxt;
  logic [7:0]     r_status, w_status_nxt;
  logic           r_bus_grant, w_bus_grant_nxt;
  logic [7:0]     r_m_opcode, w_m_opcode_nxt;
  logic [23:0]    r_m_addr, w_m_addr_nxt;
  logic           r_m_addr_flag, w_m_addr_flag_nxt;
  logic           r_oa_trig, w_oa_trig_nxt;
  logic           r_data_trig, w_data_trig_nxt;
  logic           r_finalize, w_finalize_nxt;
  logic           r_oa_q, r_oa_q2, r_dc_q, r_dc_q2;
  logic           w_oa_edge, w_dc_edge, w_fin_done;

  assign w_oa_edge = r_oa_q & ~r_oa_q2;
  assign w_dc_edge = r_dc_q & ~r_dc_q2;
  assign w_cnt_inc = {1'b0, r_poll_cnt} + (CNT_W + 1)'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_fin_ph      <= F_PULSE;
      r_gap         <= '0;
      r_poll_cnt    <= '0;
      r_err_pend    <= 1'b0;
      r_rearm       <= 1'b0;
      r_op          <= '0;
      r_addr        <= '0;
      r_has_addr    <= 1'b0;
      r_cmd_busy    <= 1'b0;
      r_cmd_done    <= 1'b0;
      r_cmd_error   <= 1'b0;
      r_status      <= '0;
      r_bus_grant   <= 1'b0;
      r_m_opcode    <= '0;
      r_m_addr      <= '0;
      r_m_addr_flag <= 1'b0;
      r_oa_trig     <= 1'b0;
      r_data_trig   <= 1'b0;
      r_finalize    <= 1'b0;
      r_oa_q        <= 1'b0;
      r_oa_q2       <= 1'b0;
      r_dc_q        <= 1'b0;
      r_dc_q2       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fin_ph      <= w_fin_ph_nxt;
      r_gap         <= w_gap_nxt;
      r_poll_cnt    <= w_poll_cnt_nxt;
      r_err_pend    <= w_err_pend_nxt;
      r_rearm       <= w_rearm_nxt;
      r_op          <= w_op_nxt;
      r_addr        <= w_addr_nxt;
      r_has_addr    <= w_has_addr_nxt;
      r_cmd_busy    <= w_cmd_busy_nxt;
      r_cmd_done    <= w_cmd_done_nxt;
      r_cmd_error   <= w_cmd_error_nxt;
      r_status      <= w_status_nxt;
      r_bus_grant   <= w_bus_grant_nxt;
      r_m_opcode    <= w_m_opcode_nxt;
      r_m_addr      <= w_m_addr_nxt;
      r_m_addr_flag <= w_m_addr_flag_nxt;
      r_oa_trig     <= w_oa_trig_nxt;
      r_data_trig   <= w_data_trig_nxt;
      r_finalize    <= w_finalize_nxt;
      r_oa_q        <= i_m_oa_completed;
      r_oa_q2       <= r_oa_q;
      r_dc_q        <= i_m_data_completed;
      r_dc_q2       <= r_dc_q;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_fin_ph_nxt      = r_fin_ph;
    w_gap_nxt         = r_gap;
    w_poll_cnt_nxt    = r_poll_cnt;
    w_err_pend_nxt    = r_err_pend;
    w_rearm_nxt       = r_rearm;
    w_op_nxt          = r_op;
    w_addr_nxt        = r_addr;
    w_has_addr_nxt    = r_has_addr;
    w_cmd_busy_nxt    = r_cmd_busy;
    w_cmd_done_nxt    = 1'b0;
    w_cmd_error_nxt   = 1'b0;
    w_status_nxt      = r_status;
    w_m_opcode_nxt    = r_m_opcode;
    w_m_addr_nxt      = r_m_addr;
    w_m_addr_flag_nxt = r_m_addr_flag;
    w_oa_trig_nxt     = r_oa_trig;
    w_data_trig_nxt   = r_data_trig;
    w_finalize_nxt    = 1'b0;
    w_fin_done        = 1'b0;
    // New grants only from a truly idle engine; an existing grant lives until bus_req drops.
    w_bus_grant_nxt   = i_bus_req & (r_bus_grant | ((r_state == S_IDLE) & ~i_cmd_start));

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        w_state_nxt = S_IDLE;
        if (i_cmd_start) begin
          w_op_nxt       = i_cmd_opcode;
          w_addr_nxt     = i_cmd_addr;
          w_has_addr_nxt = i_cmd_has_addr;
          w_cmd_busy_nxt = 1'b1;
          w_poll_cnt_nxt = '0;
          w_err_pend_nxt = 1'b0;
          w_state_nxt    = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (!r_bus_grant && !i_m_busy) begin
          w_m_opcode_nxt    = OP_WREN;
          w_m_addr_nxt      = '0;
          w_m_addr_flag_nxt = 1'b0;
          w_oa_trig_nxt     = 1'b1;
          w_state_nxt       = S_WREN_OA;
        end
      end
      S_WREN_OA, S_OP_OA, S_RDSR_OA: begin
        if (w_oa_edge) begin
          w_oa_trig_nxt = 1'b0;
          w_fin_ph_nxt  = F_PULSE;
          if (r_state == S_RDSR_OA) begin
            w_data_trig_nxt = 1'b1;
            w_rearm_nxt     = 1'b0;
            w_state_nxt     = S_RDSR_DATA;
          end else begin
            w_state_nxt = (r_state == S_WREN_OA) ? S_WREN_FIN : S_OP_FIN;
          end
        end
      end
      S_RDSR_DATA: begin
        if (r_rearm) begin
          w_data_trig_nxt = 1'b1;
          w_rearm_nxt     = 1'b0;
        end else if (w_dc_edge) begin
          w_data_trig_nxt = 1'b0;
          w_status_nxt    = i_m_read_data;
          w_fin_ph_nxt    = F_PULSE;
          if (!i_m_read_data[0]) begin
            w_state_nxt = S_RDSR_FIN;
          end else begin
            w_poll_cnt_nxt = CNT_W'(w_cnt_inc);
            if (w_cnt_inc == CNT_LIMIT) begin
              w_err_pend_nxt = 1'b1;
              w_state_nxt    = S_RDSR_FIN;
            end else begin
              w_rearm_nxt = 1'b1;
            end
          end
        end
      end
      S_WREN_FIN, S_OP_FIN, S_RDSR_FIN: begin
        case (r_fin_ph)
          F_PULSE: begin
            w_finalize_nxt = 1'b1;
            w_fin_ph_nxt   = F_HOLD;
          end
          F_HOLD: w_fin_ph_nxt = F_WAIT;
          F_WAIT: begin
            if (!i_m_busy) begin
              w_fin_ph_nxt = F_GAP;
              w_gap_nxt    = '0;
            end
          end
          default: begin
            if (r_gap != GAP_LAST) w_gap_nxt = r_gap + GAP_W'(1);
            else w_fin_done = 1'b1;
          end
        endcase
        if (w_fin_done) begin
          w_fin_ph_nxt = F_PULSE;
          case (r_state)
            S_WREN_FIN: begin
              w_m_opcode_nxt    = r_op;
              w_m_addr_nxt      = r_addr;
              w_m_addr_flag_nxt = r_has_addr;
              w_oa_trig_nxt     = 1'b1;
              w_state_nxt       = S_OP_OA;
            end
            S_OP_FIN: begin
              w_m_opcode_nxt    = OP_RDSR;
              w_m_addr_nxt      = '0;
              w_m_addr_flag_nxt = 1'b0;
              w_oa_trig_nxt     = 1'b1;
              w_state_nxt       = S_RDSR_OA;
            end
            default: begin
              w_cmd_busy_nxt  = 1'b0;
              w_poll_cnt_nxt  = '0;
              w_cmd_error_nxt = r_err_pend;
              w_cmd_done_nxt  = ~r_err_pend;
              w_state_nxt     = r_err_pend ? S_ERR : S_DONE;
            end
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_cmd_busy       = r_cmd_busy;
  assign o_cmd_done       = r_cmd_done;
  assign o_cmd_error      = r_cmd_error;
  assign o_status_byte    = r_status;
  assign o_bus_grant      = r_bus_grant;
  assign o_m_opcode       = r_m_opcode;
  assign o_m_addr         = r_m_addr;
  assign o_m_addr_flag    = r_m_addr_flag;
  assign o_m_oa_trigger   = r_oa_trig;
  assign o_m_data_trigger = r_data_trig;
  assign o_m_finalize     = r_finalize;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed bench for flash_cmd_sequencer with a behavioural SPI master / flash status model.
module tb_flash_cmd_sequencer;

  localparam int unsigned POLL_MAX = 4;
  localparam int unsigned CS_GAP   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [7:0]  cmd_opcode = '0;
  logic        cmd_has_addr = 1'b0;
  logic [23:0] cmd_addr = '0;
  logic        bus_req = 1'b0;
  logic        m_oa_completed = 1'b0;
  logic        m_data_completed = 1'b0;
  logic [7:0]  m_read_data = '0;
  logic        m_busy = 1'b0;
  logic        o_cmd_busy, o_cmd_done, o_cmd_error, o_bus_grant;
  logic [7:0]  o_status_byte, o_m_opcode;
  logic [23:0] o_m_addr;
  logic        o_m_addr_flag, o_m_oa_trigger, o_m_data_trigger, o_m_finalize;

  always #5 clk = ~clk;

  flash_cmd_sequencer #(.POLL_MAX(POLL_MAX), .CS_GAP(CS_GAP)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_start(cmd_start), .i_cmd_opcode(cmd_opcode),
    .i_cmd_has_addr(cmd_has_addr), .i_cmd_addr(cmd_addr),
    .o_cmd_busy(o_cmd_busy), .o_cmd_done(o_cmd_done), .o_cmd_error(o_cmd_error),
    .o_status_byte(o_status_byte),
    .i_bus_req(bus_req), .o_bus_grant(o_bus_grant),
    .o_m_opcode(o_m_opcode), .o_m_addr(o_m_addr), .o_m_addr_flag(o_m_addr_flag),
    .o_m_oa_trigger(o_m_oa_trigger), .i_m_oa_completed(m_oa_completed),
    .o_m_data_trigger(o_m_data_trigger), .i_m_data_completed(m_data_completed),
    .i_m_read_data(m_read_data), .o_m_finalize(o_m_finalize), .i_m_busy(m_busy)
  );

  typedef struct {
    logic [7:0]  op;
    logic        has_addr;
    logic [23:0] addr;
    int          n_wip;      // status reads returning sr_wip before sr_final
    logic [7:0]  sr_wip;
    logic [7:0]  sr_final;
    logic        exp_err;
    int          exp_rd;
    logic [7:0]  exp_status;
    int          exp_len;
  } vec_t;

  vec_t vecs[5];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;

  int rd_cnt, sr_n_wip;
  logic [7:0] sr_wip, sr_final;
  logic [7:0] bus_q[$];
  int oa_wait = 0, data_wait = 0, fin_wait = 0;
  int fin_cnt = 0, done_cnt = 0, err_cnt = 0;
  int grant_busy = 0, act_grant = 0, busy_overlap = 0;
  int gap_start = 0;
  bit have_gap = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Master + flash model, evaluated away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      m_oa_completed = 1'b0; m_data_completed = 1'b0; m_busy = 1'b0; m_read_data = '0;
      oa_wait = 0; data_wait = 0; fin_wait = 0; have_gap = 0;
    end else begin
      if (o_m_finalize) begin
        fin_cnt++;
        fin_wait = 2;
      end else if (fin_wait > 0) begin
        fin_wait--;
        if (fin_wait == 0) begin
          m_busy = 1'b0; gap_start = cyc; have_gap = 1;
        end
      end
      if (o_m_oa_trigger) begin
        if (!m_busy) begin
          if (have_gap) check("cs_gap", 64'((cyc - gap_start) >= int'(CS_GAP)), 64'd1);
          m_busy = 1'b1;
        end
        if (!m_oa_completed) begin
          oa_wait++;
          if (oa_wait == 2) begin
            m_oa_completed = 1'b1;
            bus_q.push_back(o_m_opcode);
            if (o_m_addr_flag) begin
              bus_q.push_back(o_m_addr[23:16]);
              bus_q.push_back(o_m_addr[15:8]);
              bus_q.push_back(o_m_addr[7:0]);
            end
          end
        end
      end else begin
        m_oa_completed = 1'b0; oa_wait = 0;
      end
      if (o_m_data_trigger) begin
        if (!m_data_completed) begin
          data_wait++;
          if (data_wait == 3) begin
            m_data_completed = 1'b1;
            m_read_data = (rd_cnt < sr_n_wip) ? sr_wip : sr_final;
            bus_q.push_back(m_read_data);
            rd_cnt++;
          end
        end
      end else begin
        m_data_completed = 1'b0; data_wait = 0;
      end
    end
    if (o_cmd_done) done_cnt++;
    if (o_cmd_error) err_cnt++;
    if ((o_cmd_done || o_cmd_error) && o_cmd_busy) busy_overlap++;
    if (o_bus_grant && o_cmd_busy) grant_busy++;
    if (o_bus_grant && (o_m_oa_trigger || o_m_data_trigger || o_m_finalize)) act_grant++;
  end

  task automatic start_cmd(input logic [7:0] op, input logic ha, input logic [23:0] a);
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_opcode = op; cmd_has_addr = ha; cmd_addr = a;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_cmd_done || o_cmd_error) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic clear_model(input int nw, input logic [7:0] sw, input logic [7:0] sf);
    bus_q.delete();
    rd_cnt = 0; sr_n_wip = nw; sr_wip = sw; sr_final = sf;
    done_cnt = 0; err_cnt = 0; busy_overlap = 0; grant_busy = 0; act_grant = 0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    bit ok;
    logic [7:0] exp_q[$];
    v = vecs[idx];
    clear_model(v.n_wip, v.sr_wip, v.sr_final);
    start_cmd(v.op, v.has_addr, v.addr);
    check($sformatf("v%0d_busy", idx), 64'(o_cmd_busy), 64'd1);
    repeat (6) @(posedge clk);
    #1 cmd_start = 1'b1; cmd_opcode = 8'hAB; cmd_has_addr = 1'b1; cmd_addr = 24'hABCDEF;
    @(posedge clk); #1 cmd_start = 1'b0;
    wait_end(2000, ok);
    check($sformatf("v%0d_end_seen", idx), 64'(ok), 64'd1);
    repeat (4) @(negedge clk);
    check($sformatf("v%0d_done_cnt", idx), 64'(done_cnt), 64'(!v.exp_err));
    check($sformatf("v%0d_err_cnt", idx), 64'(err_cnt), 64'(v.exp_err));
    check($sformatf("v%0d_busy_at_end", idx), 64'(busy_overlap), 64'd0);
    check($sformatf("v%0d_status", idx), 64'(o_status_byte), 64'(v.exp_status));
    check($sformatf("v%0d_rd_bytes", idx), 64'(rd_cnt), 64'(v.exp_rd));
    check($sformatf("v%0d_idle_busy", idx), 64'(o_cmd_busy), 64'd0);
    exp_q.push_back(8'h06);
    exp_q.push_back(v.op);
    if (v.has_addr) begin
      exp_q.push_back(v.addr[23:16]);
      exp_q.push_back(v.addr[15:8]);
      exp_q.push_back(v.addr[7:0]);
    end
    exp_q.push_back(8'h05);
    for (int k = 0; k < v.exp_rd; k++) exp_q.push_back((k < v.n_wip) ? v.sr_wip : v.sr_final);
    check($sformatf("v%0d_bus_len", idx), 64'(bus_q.size()), 64'(v.exp_len));
    for (int k = 0; k < exp_q.size() && k < bus_q.size(); k++)
      check($sformatf("v%0d_bus_byte%0d", idx, k), 64'(bus_q[k]), 64'(exp_q[k]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int fin_snap;
    vecs[0] = '{8'h20, 1'b1, 24'h012000, 2,  8'h03, 8'h00, 1'b0, 3, 8'h00, 9};
    vecs[1] = '{8'hC7, 1'b0, 24'h000000, 0,  8'h03, 8'h00, 1'b0, 1, 8'h00, 4};
    vecs[2] = '{8'h02, 1'b1, 24'hFFFFFF, 1,  8'h03, 8'h02, 1'b0, 2, 8'h02, 8};
    vecs[3] = '{8'hD8, 1'b1, 24'h000000, 99, 8'h01, 8'h00, 1'b1, 4, 8'h01, 10};
    vecs[4] = '{8'h52, 1'b1, 24'h7FF000, 3,  8'h81, 8'h80, 1'b0, 4, 8'h80, 10};
    clear_model(0, 8'h00, 8'h00);

    repeat (3) @(negedge clk);
    check("reset_outputs", {o_cmd_busy, o_cmd_done, o_cmd_error, o_status_byte, o_bus_grant,
          o_m_opcode, o_m_addr, o_m_addr_flag, o_m_oa_trigger, o_m_data_trigger, o_m_finalize}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Bridge holds the master; a command started meanwhile must wait for release.
    clear_model(0, 8'h00, 8'h00);
    @(posedge clk); #1 bus_req = 1'b1;
    repeat (2) @(negedge clk);
    check("arb_grant", 64'(o_bus_grant), 64'd1);
    start_cmd(8'h20, 1'b1, 24'h012000);
    repeat (20) @(negedge clk);
    check("arb_no_bus_activity", 64'(bus_q.size()), 64'd0);
    check("arb_busy", 64'(o_cmd_busy), 64'd1);
    check("arb_grant_held", 64'(o_bus_grant), 64'd1);
    @(posedge clk); #1 bus_req = 1'b0;
    repeat (2) @(negedge clk);
    check("arb_release", 64'(o_bus_grant), 64'd0);
    wait_end(2000, ok);
    check("arb_end_seen", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    check("arb_done_cnt", 64'(done_cnt), 64'd1);
    check("arb_bus_len", 64'(bus_q.size()), 64'd7);
    if (bus_q.size() > 0) check("arb_first_wren", 64'(bus_q[0]), 64'h06);
    check("arb_act_under_grant", 64'(act_grant), 64'd0);

    // Same-cycle cmd_start and bus_req: command wins, grant waits for IDLE.
    clear_model(0, 8'h00, 8'h00);
    @(posedge clk); #1;
    cmd_start = 1'b1; bus_req = 1'b1; cmd_opcode = 8'hC7; cmd_has_addr = 1'b0; cmd_addr = '0;
    @(posedge clk); #1 cmd_start = 1'b0;
    check("tie_busy", 64'(o_cmd_busy), 64'd1);
    wait_end(2000, ok);
    check("tie_end_seen", 64'(ok), 64'd1);
    check("tie_no_grant_during_cmd", 64'(grant_busy), 64'd0);
    check("tie_bus_len", 64'(bus_q.size()), 64'd4);
    @(negedge clk);
    check("tie_grant_idle_cycle", 64'(o_bus_grant), 64'd0);
    @(negedge clk);
    check("tie_grant_after_idle", 64'(o_bus_grant), 64'd1);
    @(posedge clk); #1 bus_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while polling status: everything clears, no finalize, no pulses.
    clear_model(99, 8'h01, 8'h00);
    start_cmd(8'h20, 1'b1, 24'h012000);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rd_cnt >= 1) begin
        ok = 1;
        break;
      end
    end
    check("rst_reached_rdsr", 64'(ok), 64'd1);
    repeat (5) @(posedge clk);
    fin_snap = fin_cnt;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_outputs", {o_cmd_busy, o_cmd_done, o_cmd_error, o_status_byte, o_bus_grant,
          o_m_opcode, o_m_addr, o_m_addr_flag, o_m_oa_trigger, o_m_data_trigger, o_m_finalize}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_finalize", 64'(fin_cnt), 64'(fin_snap));
    check("rst_no_done", 64'(done_cnt), 64'd0);
    check("rst_no_error", 64'(err_cnt), 64'd0);
    run_vec(1);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
